// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin burst arbiter: rotating-priority pick, per-owner
// transaction budget, watchdog-terminated transactions.
module wrr_burst_arbiter #(
  parameter int NUM_REQS  = 4,
  parameter int WGT_W     = 3,
  parameter int MAX_BURST = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQS-1:0]         req_i,
  input  logic                        last_i,
  input  logic [NUM_REQS*WGT_W-1:0]   weight_i,
  output logic [NUM_REQS-1:0]         grant_o,
  output logic                        grant_valid_o,
  output logic [$clog2(NUM_REQS)-1:0] grant_id_o,
  output logic                        timeout_o
);
  localparam int IDW = $clog2(NUM_REQS);
  localparam int BW  = $clog2(MAX_BURST) + 1;
  localparam logic [BW-1:0] BURST_END = BW'(MAX_BURST - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e              state_q;
  logic [NUM_REQS-1:0] grant_q;
  logic [IDW-1:0]      id_q;
  logic [IDW-1:0]      ptr_q;
  logic [BW-1:0]       burst_q;
  logic [WGT_W-1:0]    txn_q;
  logic                timeout_q;

  logic [IDW-1:0]      win_id_d;
  logic [IDW-1:0]      cand;
  logic [WGT_W-1:0]    wgt_a [NUM_REQS];
  logic [WGT_W-1:0]    eff_wgt;
  logic                more_d;

  // Walk from farthest to nearest so the first requester after the
  // last owner is the final (winning) assignment.
  always_comb begin
    win_id_d = '0;
    cand     = '0;
    for (int i = NUM_REQS; i >= 1; i--) begin
      cand = IDW'((int'(ptr_q) + i) % NUM_REQS);
      if (req_i[cand]) win_id_d = cand;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQS; k++) begin
      wgt_a[k] = weight_i[k*WGT_W +: WGT_W];
    end
  end

  always_comb begin
    eff_wgt = (wgt_a[id_q] == '0) ? WGT_W'(1) : wgt_a[id_q];
    more_d  = (({1'b0, txn_q} + (WGT_W+1)'(1)) < {1'b0, eff_wgt})
              && req_i[id_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      ptr_q     <= IDW'(NUM_REQS - 1);
      burst_q   <= '0;
      txn_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (|req_i) begin
            state_q <= GRANT;
            grant_q <= NUM_REQS'(1) << win_id_d;
            id_q    <= win_id_d;
            burst_q <= '0;
            txn_q   <= '0;
          end
        end
        GRANT: begin
          if (last_i && more_d) begin
            txn_q   <= txn_q + WGT_W'(1);
            burst_q <= '0;
          end else if (last_i || burst_q == BURST_END) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            ptr_q     <= id_q;
            burst_q   <= '0;
            txn_q     <= '0;
            timeout_q <= !last_i;
          end else begin
            burst_q <= burst_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = |grant_q;
  assign grant_id_o    = id_q;
  assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Bench for wrr_burst_arbiter: grant episodes (owner, length, timeout)
// are queued by the stimulus and checked by a negedge monitor.
module tb_wrr_burst_arbiter;
  localparam int N  = 4;
  localparam int WW = 3;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_i = '0;
  logic          last_i = 1'b0;
  logic [N*WW-1:0] weight_i;
  logic [N-1:0]  grant_o;
  logic          grant_valid_o;
  logic [1:0]    grant_id_o;
  logic          timeout_o;

  wrr_burst_arbiter #(
    .NUM_REQS(N), .WGT_W(WW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .last_i(last_i),
    .weight_i(weight_i), .grant_o(grant_o),
    .grant_valid_o(grant_valid_o), .grant_id_o(grant_id_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int len;
    int to;
  } ep_t;

  ep_t expq[$];
  int  total = 0;
  int  bad = 0;
  int  nstart = 0;
  bit  sb_en = 1'b1;

  task automatic check(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic push(input int id, input int len, input int to);
    ep_t e;
    e.id = id;
    e.len = len;
    e.to = to;
    expq.push_back(e);
  endtask

  // Owner-side last_i generator: last_i in the per-th cycle of each txn.
  int per = 1;
  bit rmode = 1'b0;
  int tcnt = 0;
  bit was_v = 1'b0;
  bit was_last = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rst || !was_v || was_last) tcnt = 0;
    else tcnt++;
    if (rmode) last_i = ($urandom_range(3) == 0);
    else last_i = grant_valid_o && per != 0 && (tcnt + 1 == per);
    was_v = grant_valid_o;
    was_last = last_i;
  end

  // Monitor
  bit prev_v = 1'b0;
  int cur_id = 0;
  int cur_len = 0;

  always @(negedge clk) begin
    ep_t e;
    check("onehot", int'($onehot0(grant_o)), 1);
    check("valid_or", int'(grant_valid_o), int'(|grant_o));
    if (grant_valid_o) check("id_bit", int'(grant_o[grant_id_o]), 1);
    else check("id_idle", int'(grant_id_o), 0);
    if (grant_valid_o && !prev_v) begin
      nstart++;
      cur_id = int'(grant_id_o);
      cur_len = 1;
    end else if (grant_valid_o) begin
      cur_len++;
      check("id_stable", int'(grant_id_o), cur_id);
    end
    if (!grant_valid_o && prev_v) begin
      if (sb_en) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ep id=%0d len=%0d", cur_id, cur_len);
        end else begin
          e = expq.pop_front();
          check("ep_id", cur_id, e.id);
          check("ep_len", cur_len, e.len);
          check("ep_timeout", int'(timeout_o), e.to);
        end
      end
    end else begin
      check("stray_timeout", int'(timeout_o), 0);
    end
    prev_v = grant_valid_o;
  end

  task automatic wait_starts(input int k);
    int tgt = nstart + k;
    int b = 0;
    while (nstart < tgt && b < 300) begin
      @(negedge clk);
      #1;
      b++;
    end
    check("wait_start", int'(nstart >= tgt), 1);
  endtask

  task automatic wait_idle();
    int b = 0;
    while ((expq.size() != 0 || grant_valid_o) && b < 300) begin
      @(negedge clk);
      #1;
      b++;
    end
    check("wait_idle", expq.size(), 0);
  endtask

  int wt[N];
  int mx[N];
  logic [N-1:0] r;

  initial begin
    weight_i = {3'd1, 3'd1, 3'd1, 3'd1};
    repeat (3) @(negedge clk);
    #1;
    check("rst_grant", int'(grant_o), 0);
    check("rst_valid", int'(grant_valid_o), 0);
    check("rst_id", int'(grant_id_o), 0);
    check("rst_timeout", int'(timeout_o), 0);

    // 1: full rotation, weight 1
    rst = 1'b0;
    per = 1;
    push(0, 1, 0); push(1, 1, 0); push(2, 1, 0);
    push(3, 1, 0); push(0, 1, 0);
    req_i = 4'b1111;
    wait_starts(5);
    req_i = 4'b0000;
    wait_idle();

    // 2: weight 3 back-to-back, then re-grant dropped after one txn
    weight_i = {3'd1, 3'd3, 3'd1, 3'd1};
    per = 2;
    push(2, 6, 0); push(2, 2, 0);
    req_i = 4'b0100;
    wait_starts(1);
    wait_starts(1);
    req_i = 4'b0000;
    wait_idle();

    // 3: watchdog on owner 1, then rotation to 2
    weight_i = {3'd1, 3'd1, 3'd1, 3'd1};
    per = 0;
    push(1, MB, 1); push(2, 1, 0);
    req_i = 4'b0010;
    wait_starts(1);
    req_i = 4'b1111;
    per = 1;
    wait_starts(1);
    req_i = 4'b0000;
    wait_idle();

    // 4: owner 3 drops req mid-txn with weight 2
    weight_i = {3'd2, 3'd1, 3'd1, 3'd1};
    per = 3;
    push(3, 3, 0); push(0, 3, 0);
    req_i = 4'b1000;
    wait_starts(1);
    req_i = 4'b0001;
    wait_starts(1);
    req_i = 4'b0000;
    wait_idle();

    // 5: reset mid-grant
    weight_i = {3'd1, 3'd1, 3'd1, 3'd1};
    per = 0;
    push(2, 3, 0);
    req_i = 4'b0100;
    wait_starts(1);
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("async_grant", int'(grant_o), 0);
    check("async_valid", int'(grant_valid_o), 0);
    @(negedge clk);
    #1;
    per = 1;
    req_i = 4'b1010;
    push(1, 1, 0);
    rst = 1'b0;
    wait_starts(1);
    req_i = 4'b0000;
    wait_idle();

    // 6: random traffic, starvation bound
    sb_en = 1'b0;
    rmode = 1'b1;
    weight_i = N*WW'($urandom);
    for (int k = 0; k < N; k++) begin
      wt[k] = 0;
      mx[k] = 0;
    end
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      #1;
      r = req_i;
      for (int k = 0; k < N; k++) begin
        if (grant_o[k]) begin
          wt[k] = 0;
          if ($urandom_range(1) == 0) r[k] = 1'b0;
        end else if (r[k]) begin
          wt[k]++;
          if (wt[k] > mx[k]) mx[k] = wt[k];
        end else if ($urandom_range(3) == 0) begin
          r[k] = 1'b1;
        end
      end
      req_i = r;
    end
    req_i = 4'b0000;
    rmode = 1'b0;
    per = 1;
    wait_idle();
    for (int k = 0; k < N; k++) begin
      check("starve", int'(mx[k] <= 200), 1);
    end

    check("queue_empty", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
